// File: rtl/custom_leds_pwm_if.sv
// Avalon-MM slave bus bundle for the LED PWM controller.
// Signals: address (word address), read/write strobes, 32-bit writedata,
// 32-bit readdata (fixed read latency 1, no waitrequest).
// master: bus initiator (bridge / testbench); slave: the LED controller.
interface custom_leds_pwm_if #(
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [31:0]       readdata;

   modport master (
      output address, read, write, writedata,
      input  readdata
   );

   modport slave (
      input  address, read, write, writedata,
      output readdata
   );
endinterface

// File: rtl/custom_leds_pwm.sv
// Avalon-MM LED controller with per-LED off/on/blink/PWM modes.
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   avs          Avalon-MM slave bus (custom_leds_pwm_if.slave)
//   leds_conduit registered LED drive, 1 = lit
// Register map (word addresses): 0 CTRL, 1 PRESCALE, 2 BLINK_HALF, 3 INFO,
// 4+i LED_CFG[i] = {DUTY at [8+PWM_BITS-1:8], MODE at [1:0]}.
module custom_leds_pwm #(
   parameter int unsigned NUM_LEDS   = 8,
   parameter int unsigned PWM_BITS   = 8,
   parameter int unsigned PRESCALE_W = 16,
   parameter int unsigned BLINK_W    = 16,
   parameter int unsigned ADDR_W     = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   custom_leds_pwm_if.slave    avs,
   output logic [NUM_LEDS-1:0] leds_conduit
);

   localparam int unsigned CFG_BASE = 4;
   localparam int unsigned DUTY_LSB = 8;

   // Register state
   logic                  en_q, en_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [BLINK_W-1:0]    blink_half_q, blink_half_d;
   logic [1:0]            mode_q [NUM_LEDS];
   logic [1:0]            mode_d [NUM_LEDS];
   logic [PWM_BITS-1:0]   duty_q [NUM_LEDS];
   logic [PWM_BITS-1:0]   duty_d [NUM_LEDS];
   logic [PWM_BITS-1:0]   shadow_q [NUM_LEDS];
   logic [PWM_BITS-1:0]   shadow_d [NUM_LEDS];

   // Timebase state
   logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
   logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
   logic                  blink_phase_q, blink_phase_d;

   // Outputs
   logic [NUM_LEDS-1:0]   leds_q, leds_d;
   logic [31:0]           rdata_q, rdata_d;

   logic wr_ctrl_c, wr_pre_c, wr_blink_c;
   logic tick_c, frame_end_c;
   logic unused_wdata_c;

   // Every writedata bit may be dropped for some parameter choice
   assign unused_wdata_c = ^avs.writedata;

   assign leds_conduit = leds_q;
   assign avs.readdata = rdata_q;

   // Write decode and timebase strobes
   always_comb begin
      wr_ctrl_c   = avs.write && (avs.address == ADDR_W'(0));
      wr_pre_c    = avs.write && (avs.address == ADDR_W'(1));
      wr_blink_c  = avs.write && (avs.address == ADDR_W'(2));
      tick_c      = en_q && (pre_cnt_q == prescale_q);
      frame_end_c = tick_c && (pwm_cnt_q == '1);
   end

   // Register file next state; shadow duty captures the post-write value
   always_comb begin
      en_d         = en_q;
      prescale_d   = prescale_q;
      blink_half_d = blink_half_q;
      if (wr_ctrl_c)  en_d         = avs.writedata[0];
      if (wr_pre_c)   prescale_d   = avs.writedata[PRESCALE_W-1:0];
      if (wr_blink_c) blink_half_d = avs.writedata[BLINK_W-1:0];
      for (int i = 0; i < NUM_LEDS; i++) begin
         mode_d[i]   = mode_q[i];
         duty_d[i]   = duty_q[i];
         shadow_d[i] = shadow_q[i];
         if (avs.write && (avs.address == ADDR_W'(CFG_BASE + i))) begin
            mode_d[i] = avs.writedata[1:0];
            duty_d[i] = avs.writedata[DUTY_LSB +: PWM_BITS];
         end
         if (frame_end_c) shadow_d[i] = duty_d[i];
      end
   end

   // Prescaler, PWM counter and blink timer; all parked at zero while disabled
   always_comb begin
      pre_cnt_d     = pre_cnt_q;
      pwm_cnt_d     = pwm_cnt_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (!en_q) begin
         pre_cnt_d     = '0;
         pwm_cnt_d     = '0;
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else begin
         if (wr_pre_c || tick_c) pre_cnt_d = '0;
         else                    pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
         if (tick_c) pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
         // A BLINK_HALF write restarts the half-period without touching the phase
         if (wr_blink_c) begin
            blink_cnt_d = '0;
         end else if (frame_end_c) begin
            if (blink_cnt_q == blink_half_q) begin
               blink_cnt_d   = '0;
               blink_phase_d = ~blink_phase_q;
            end else begin
               blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
         end
      end
   end

   // Per-LED output function from current-cycle state
   always_comb begin
      leds_d = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         if (en_q) begin
            unique case (mode_q[i])
               2'd0:    leds_d[i] = 1'b0;
               2'd1:    leds_d[i] = 1'b1;
               2'd2:    leds_d[i] = blink_phase_q;
               default: leds_d[i] = (pwm_cnt_q < shadow_q[i]);
            endcase
         end
      end
   end

   // Read mux; returns pre-write register values and holds between reads
   always_comb begin
      rdata_d = rdata_q;
      if (avs.read) begin
         rdata_d = '0;
         if (avs.address == ADDR_W'(0)) rdata_d = 32'(en_q);
         if (avs.address == ADDR_W'(1)) rdata_d = 32'(prescale_q);
         if (avs.address == ADDR_W'(2)) rdata_d = 32'(blink_half_q);
         if (avs.address == ADDR_W'(3))
            rdata_d = {8'h02, 4'h0, 4'(PWM_BITS), 8'h00, 8'(NUM_LEDS)};
         for (int i = 0; i < NUM_LEDS; i++) begin
            if (avs.address == ADDR_W'(CFG_BASE + i))
               rdata_d = (32'(duty_q[i]) << DUTY_LSB) | 32'(mode_q[i]);
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_q          <= 1'b0;
         prescale_q    <= '0;
         blink_half_q  <= '0;
         pre_cnt_q     <= '0;
         pwm_cnt_q     <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         leds_q        <= '0;
         rdata_q       <= '0;
         for (int i = 0; i < NUM_LEDS; i++) begin
            mode_q[i]   <= '0;
            duty_q[i]   <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         en_q          <= en_d;
         prescale_q    <= prescale_d;
         blink_half_q  <= blink_half_d;
         pre_cnt_q     <= pre_cnt_d;
         pwm_cnt_q     <= pwm_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         leds_q        <= leds_d;
         rdata_q       <= rdata_d;
         for (int i = 0; i < NUM_LEDS; i++) begin
            mode_q[i]   <= mode_d[i];
            duty_q[i]   <= duty_d[i];
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

endmodule

// File: tb/tb_custom_leds_pwm.sv
// Self-checking bench for custom_leds_pwm: register table plus timed
// sequences for static modes, PWM duty, duty shadowing, blink and reset.
module tb_custom_leds_pwm;

   localparam int unsigned NUM_LEDS = 8;
   localparam int unsigned ADDR_W   = 5;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic [NUM_LEDS-1:0] leds;

   custom_leds_pwm_if #(.ADDR_W(ADDR_W)) bus ();

   custom_leds_pwm #(
      .NUM_LEDS(NUM_LEDS), .PWM_BITS(8), .PRESCALE_W(16), .BLINK_W(16), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .avs(bus), .leds_conduit(leds)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      bit                is_wr;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;   // write data, or expected read data
      string             name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.address = a; bus.writedata = d; bus.write = 1'b1;
      @(negedge clk);
      bus.write = 1'b0;
   endtask

   task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.address = a; bus.read = 1'b1;
      @(negedge clk);
      bus.read = 1'b0;
      d = bus.readdata;
   endtask

   task automatic count_high(input int b, input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (leds[b]) cnt++;
      end
   endtask

   // Cycles until leds[b] changes, or -1 if it does not within limit
   task automatic wait_toggle(input int b, input int limit, output int n);
      logic prev;
      prev = leds[b];
      n = 0;
      while (n < limit) begin
         @(negedge clk);
         n++;
         if (leds[b] !== prev) return;
      end
      n = -1;
   endtask

   initial begin
      logic [31:0] rd;
      int          cnt;
      int          n;
      logic        prev;
      bit          found;

      bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;

      // Register access table
      vecs.push_back('{1'b0, 5'd3,  32'h0208_0008, "info"});
      vecs.push_back('{1'b0, 5'd1,  32'h0000_0000, "pre_rst"});
      vecs.push_back('{1'b1, 5'd1,  32'hFFFF_1234, "w_pre"});
      vecs.push_back('{1'b0, 5'd1,  32'h0000_1234, "pre_rb"});
      vecs.push_back('{1'b1, 5'd2,  32'hABCD_5678, "w_blink"});
      vecs.push_back('{1'b0, 5'd2,  32'h0000_5678, "blink_rb"});
      vecs.push_back('{1'b1, 5'd0,  32'hFFFF_FFFF, "w_ctrl1"});
      vecs.push_back('{1'b0, 5'd0,  32'h0000_0001, "ctrl_rb1"});
      vecs.push_back('{1'b1, 5'd0,  32'h0000_0000, "w_ctrl0"});
      vecs.push_back('{1'b0, 5'd0,  32'h0000_0000, "ctrl_rb0"});
      vecs.push_back('{1'b1, 5'd4,  32'hFFFF_FFFF, "w_cfg0"});
      vecs.push_back('{1'b0, 5'd4,  32'h0000_FF03, "cfg0_rb"});
      vecs.push_back('{1'b1, 5'd5,  32'h0000_41FE, "w_cfg1"});
      vecs.push_back('{1'b0, 5'd5,  32'h0000_4102, "cfg1_rb"});
      vecs.push_back('{1'b0, 5'd20, 32'h0000_0000, "unmapped20"});
      vecs.push_back('{1'b1, 5'd31, 32'hFFFF_FFFF, "w_addr31"});
      vecs.push_back('{1'b0, 5'd1,  32'h0000_1234, "pre_after31"});
      vecs.push_back('{1'b0, 5'd0,  32'h0000_0000, "ctrl_after31"});
      vecs.push_back('{1'b0, 5'd11, 32'h0000_0000, "cfg7_after31"});
      vecs.push_back('{1'b0, 5'd12, 32'h0000_0000, "unmapped12"});

      repeat (3) @(negedge clk);
      check("reset_leds", 32'(leds), 32'h0);
      check("reset_rdata", bus.readdata, 32'h0);
      reset_n = 1'b1;

      foreach (vecs[k]) begin
         if (vecs[k].is_wr) bus_write(vecs[k].addr, vecs[k].data);
         else begin
            bus_read(vecs[k].addr, rd);
            check(vecs[k].name, rd, vecs[k].data);
         end
      end

      // Back-to-back reads of addr 4 then 5, then hold
      @(negedge clk);
      bus.address = 5'd4; bus.read = 1'b1;
      @(negedge clk);
      check("b2b_first", bus.readdata, 32'h0000_FF03);
      bus.address = 5'd5;
      @(negedge clk);
      bus.read = 1'b0;
      check("b2b_second", bus.readdata, 32'h0000_4102);
      @(negedge clk);
      check("rdata_hold", bus.readdata, 32'h0000_4102);

      // Same-cycle read and write of PRESCALE returns the old value
      @(negedge clk);
      bus.address = 5'd1; bus.read = 1'b1; bus.write = 1'b1; bus.writedata = 32'h55;
      @(negedge clk);
      bus.read = 1'b0; bus.write = 1'b0;
      check("rw_same_old", bus.readdata, 32'h0000_1234);
      bus_read(5'd1, rd);
      check("rw_same_new", rd, 32'h0000_0055);

      // Static modes
      bus_write(5'd1, 32'h0);
      bus_write(5'd4, 32'h0);
      bus_write(5'd5, 32'h0);
      bus_write(5'd0, 32'h1);
      @(negedge clk);
      check("all_off", 32'(leds), 32'h0);
      bus_write(5'd4, 32'h1);
      check("static_pre", 32'(leds), 32'h0);
      @(negedge clk);
      check("static_on", 32'(leds), 32'h01);

      // PWM duty 64 over three frames, then duty 0
      bus_write(5'd6, 32'h0000_4003);
      repeat (512) @(negedge clk);
      for (int f = 0; f < 3; f++) begin
         count_high(2, 256, cnt);
         check($sformatf("pwm64_frame%0d", f), 32'(cnt), 32'd64);
      end
      bus_write(5'd6, 32'h0000_0003);
      repeat (512) @(negedge clk);
      count_high(2, 256, cnt);
      check("pwm_duty0", 32'(cnt), 32'd0);

      // Shadowing: duty 64 -> 192 written mid-frame
      bus_write(5'd6, 32'h0000_4003);
      repeat (512) @(negedge clk);
      found = 1'b0;
      prev  = leds[2];
      for (int j = 0; j < 600 && !found; j++) begin
         @(negedge clk);
         if (leds[2] && !prev) found = 1'b1;
         prev = leds[2];
      end
      check("shadow_sync", 32'(found), 32'd1);
      cnt = 1;
      for (int j = 1; j < 256; j++) begin
         @(negedge clk);
         if (leds[2]) cnt++;
         if (j == 100) begin
            bus.address = 5'd6; bus.writedata = 32'h0000_C003; bus.write = 1'b1;
         end
         if (j == 101) bus.write = 1'b0;
      end
      check("shadow_cur_frame", 32'(cnt), 32'd64);
      count_high(2, 256, cnt);
      check("shadow_next_frame", 32'(cnt), 32'd192);
      count_high(2, 256, cnt);
      check("shadow_frame2", 32'(cnt), 32'd192);

      // Blink: PRESCALE=1, BLINK_HALF=2 -> toggle every 1536 cycles
      bus_write(5'd6, 32'h0);
      bus_write(5'd1, 32'h1);
      bus_write(5'd2, 32'h2);
      bus_write(5'd7, 32'h2);
      wait_toggle(3, 5000, n);
      check("blink_sync", 32'(n > 0), 32'd1);
      wait_toggle(3, 5000, n);
      check("blink_half1", 32'(n), 32'd1536);
      wait_toggle(3, 5000, n);
      check("blink_half2", 32'(n), 32'd1536);
      repeat (700) @(negedge clk);
      bus_write(5'd2, 32'h2);
      wait_toggle(3, 5000, n);
      check("blink_restart", 32'(n), 32'd1346);

      // Disable forces LEDs off
      bus_write(5'd0, 32'h0);
      @(negedge clk);
      check("en_off", 32'(leds), 32'h0);

      // Reset mid-PWM with a read pending
      bus_write(5'd6, 32'h0000_FF03);
      bus_write(5'd0, 32'h1);
      repeat (600) @(negedge clk);
      check("pre_reset_on", 32'(leds[0]), 32'd1);
      bus_read(5'd4, rd);
      check("pre_reset_rd", rd, 32'h0000_0001);
      @(negedge clk);
      bus.address = 5'd3; bus.read = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      check("reset_async_leds", 32'(leds), 32'h0);
      check("reset_async_rdata", bus.readdata, 32'h0);
      @(negedge clk);
      bus.read = 1'b0;
      check("reset_no_pending_rd", bus.readdata, 32'h0);
      reset_n = 1'b1;
      bus_read(5'd3, rd);
      check("info_after_reset", rd, 32'h0208_0008);
      bus_read(5'd1, rd);
      check("pre_after_reset", rd, 32'h0);
      bus_read(5'd4, rd);
      check("cfg0_after_reset", rd, 32'h0);
      bus_read(5'd0, rd);
      check("ctrl_after_reset", rd, 32'h0);
      check("leds_after_reset", 32'(leds), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/custom_leds_pwm.md
Name: custom_leds_pwm

Overview:
- Avalon-MM slave LED controller; parametrised successor to the fixed 8-bit custom_leds component on the HPS lightweight bridge.
- Drives NUM_LEDS outputs on a conduit. Each LED has its own mode: off, on, blink or PWM dimming.
- A shared prescaler sets the PWM tick. Blink is timed in PWM frames.
- Duty updates are shadowed to the frame boundary, so writes never cause glitches.

Parameters:
- NUM_LEDS, 8, number of LED channels (1..16).
- PWM_BITS, 8, PWM counter/duty width (4..12).
- PRESCALE_W, 16, prescaler register width.
- BLINK_W, 16, blink half-period register width (in PWM frames).
- ADDR_W, 5, Avalon word-address width; must satisfy 2^ADDR_W >= 4+NUM_LEDS.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- avs_address  in  ADDR_W  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, fixed latency 1
- leds_conduit  out  NUM_LEDS  registered LED drive, 1 = lit

Behaviour:
- Reset: asynchronous, active-low, all state cleared. leds_conduit=0, avs_readdata=0, CTRL=0, PRESCALE=0, BLINK_HALF=0, all LED_CFG=0, all shadow duties=0, all counters=0, blink_phase=0.
- Register map (word addresses):
  - 0 CTRL: bit0 EN, RW; other bits read 0.
  - 1 PRESCALE: [PRESCALE_W-1:0], RW.
  - 2 BLINK_HALF: [BLINK_W-1:0], RW.
  - 3 INFO: RO = {8'h02, 4'h0, PWM_BITS[3:0], 8'h00, NUM_LEDS[7:0]}.
  - 4+i LED_CFG[i]: [1:0] MODE, [8+PWM_BITS-1:8] DUTY, RW.
  - All other addresses read 0; writes to them are ignored.
- Bus handshake:
  - No waitrequest.
  - A read is sampled on cycle N; avs_readdata is valid at N+1 and holds until the next read.
  - A write takes effect at the clock edge on which it is sampled.
  - Simultaneous read and write to the same address: the read returns the old value.
  - Unused writedata bits are dropped; readback of those bits returns 0.
- Prescaler:
  - pre_cnt counts 0..PRESCALE. tick=1 on the cycle pre_cnt==PRESCALE, then pre_cnt wraps to 0.
  - PRESCALE=0 gives a tick every cycle.
  - Any write to PRESCALE clears pre_cnt on the same edge.
- PWM counter:
  - pwm_cnt (PWM_BITS wide) increments on tick and wraps from 2^PWM_BITS-1 to 0.
  - frame_end = tick && pwm_cnt==all-ones.
- Duty shadowing:
  - On frame_end, every shadow_duty[i] loads LED_CFG[i].DUTY.
  - A LED_CFG write on the same edge as frame_end is captured by the shadow, i.e. the new value wins.
- Blink:
  - blink_cnt increments on frame_end.
  - When blink_cnt==BLINK_HALF and frame_end: blink_cnt goes to 0 and blink_phase toggles.
  - Half-period is therefore BLINK_HALF+1 frames.
  - Writing BLINK_HALF clears blink_cnt but leaves blink_phase unchanged.
- Per-LED output function:
  - MODE 0 → 0.
  - MODE 1 → 1.
  - MODE 2 → blink_phase.
  - MODE 3 → (pwm_cnt < shadow_duty[i]). DUTY=0 is always off; all-ones duty gives (2^PWM_BITS-1)/2^PWM_BITS on-time.
- leds_conduit[i] is registered: it reflects the function of the current-cycle state one clock later.
- Mode changes are not shadowed and take effect on the next output register update.
- Enable:
  - EN=0 forces leds_conduit=0 and holds pre_cnt, pwm_cnt, blink_cnt and blink_phase at 0. Registers stay writable.
  - EN 0→1: counting restarts from all-zero state. The first tick occurs PRESCALE+1 cycles after the EN write edge.
- Reset mid-operation: immediate return to reset values, with no completion of a pending readdata.

Test Plan:
- Reset/INFO: assert reset_n=0 mid-PWM → leds_conduit=0 immediately. Read addr 3 → 0x02080008 with defaults; read addr 1 → 0.
- Static modes: EN=1, LED_CFG[0]=1, LED_CFG[1]=0 → leds_conduit[1:0]=2'b01 from 2 cycles after the write; other LEDs stay 0.
- PWM duty: PRESCALE=0, LED_CFG[2]={DUTY=64, MODE=3}, run 4 frames (1024 cycles) → LED2 high exactly 64 of every 256 cycles after the first frame_end. DUTY=0 → never high.
- Shadowing: change LED2 DUTY 64→192 mid-frame → current frame keeps 64 high cycles; next frame has 192.
- Blink timing: PWM_BITS=8, PRESCALE=1, BLINK_HALF=2, MODE=2 → LED toggles every 3×512=1536 cycles. Writing BLINK_HALF mid-period restarts the count.
- Bus edges: read addr 20 → 0; write addr 31 → no register changes. Back-to-back reads of addr 4 then 5 return correct data on consecutive cycles. Same-cycle read+write to addr 1 returns the old value.
